wb_port_arbiter: RTL and testbench



---
 rtl/wb_port_arbiter_pkg.sv | 19 +
 rtl/wb_pend_fifo.sv | 66 ++++++
 rtl/wb_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default register data / address widths
//   ADDR_ZERO / DATA_ZERO   : zero constants for idle write-port values
//   arb_state_t             : starvation FSM states
package wb_port_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] ADDR_ZERO = '0;
  localparam logic [DATA_W_DEF-1:0] DATA_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_FORCE
  } arb_state_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for long-latency writebacks.
// Synchronous circular buffer. The pointers carry one extra wrap bit so that
// full and empty can be told apart.
// Ports:
//   clk, rst               clock, synchronous active-high reset (flushes)
//   push, push_addr/data   enqueue, ignored while full
//   pop                    dequeue head, ignored while empty
//   full, empty, last      occupancy flags (last = exactly one entry)
//   head_addr, head_data   oldest entry (undefined while empty)
module wb_pend_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic              last,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    count;
  logic              do_push;
  logic              do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign last    = (count == (PTR_W+1)'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr = mem_addr[rd_ptr[PTR_W-1:0]];
  assign head_data = mem_data[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr[PTR_W-1:0]] <= push_addr;
      mem_data[wr_ptr[PTR_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline WB stage vs. long-latency unit.
// WB always wins; long-latency results queue in wb_pend_fifo and drain into
// idle write-port cycles. A starvation timer raises stall_req so queued
// results are guaranteed to retire.
// Build option: define WBARB_DIRECT_EN to let an lu result bypass the empty
// FIFO and write the register file in the same cycle.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   wb_we/wb_waddr/wb_wdata         pipeline WB write request
//   lu_valid/lu_waddr/lu_wdata      long-latency result, lu_ready = accepted
//   rf_we/rf_waddr/rf_wdata         register-file write port
//   stall_req                       freeze request to IF/ID/EX
//   pend_valid/pend_waddr/pend_wdata FIFO head, exported for ID bypass
//
// state    | meaning
// ST_IDLE  | FIFO empty
// ST_WAIT  | entries buffered, head waiting for an idle write cycle
// ST_FORCE | head starved too long, pipeline stall requested
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_waddr,
  output logic [DATA_W-1:0] pend_wdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [ADDR_W-1:0] A_ZERO = ADDR_W'(ADDR_ZERO);
  localparam logic [DATA_W-1:0] D_ZERO = DATA_W'(DATA_ZERO);

  arb_state_t        state, state_next;
  logic [CNT_W-1:0]  starve_cnt;
  logic              full, empty, last;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_live;
  logic              direct_pass;
  logic              push, pop;
  logic              will_empty;

  // The reset cycle treats the FIFO as empty so flushed entries never write.
  assign fifo_live = !empty && !rst;

`ifdef WBARB_DIRECT_EN
  assign direct_pass = !wb_we && !fifo_live && lu_valid && (lu_waddr != A_ZERO);
`else
  assign direct_pass = 1'b0;
`endif

  assign lu_ready = !full;
  // Address 0 results are accepted and dropped.
  assign push = lu_valid && !full && (lu_waddr != A_ZERO) && !direct_pass;
  assign pop  = !wb_we && fifo_live;

  // FIFO occupancy after this edge is zero.
  assign will_empty = empty ? !push : (last && pop && !push);

  wb_pend_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (lu_waddr),
    .push_data (lu_wdata),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .last      (last),
    .head_addr (head_addr),
    .head_data (head_data)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = A_ZERO;
    rf_wdata = D_ZERO;
    if (wb_we) begin
      rf_we    = 1'b1;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
    end else if (fifo_live) begin
      rf_we    = 1'b1;
      rf_waddr = head_addr;
      rf_wdata = head_data;
    end else if (direct_pass) begin
      rf_we    = 1'b1;
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
    end
  end

  assign pend_valid = !empty;
  assign pend_waddr = empty ? A_ZERO : head_addr;
  assign pend_wdata = empty ? D_ZERO : head_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (push) state_next = ST_WAIT;
      ST_WAIT: begin
        if (will_empty)                             state_next = ST_IDLE;
        else if (starve_cnt == CNT_W'(STARVE_MAX))  state_next = ST_FORCE;
      end
      ST_FORCE: if (will_empty) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Driven straight from the state register, so it is glitch-free and rises
  // the cycle after the FSM decides to force.
  assign stall_req = (state == ST_FORCE);

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int SM = 4;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic        pend_valid;
  logic [4:0]  pend_waddr;
  logic [31:0] pend_wdata;

  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;
  wr_t lu_q[$];

  wb_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .lu_valid   (lu_valid),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .stall_req  (stall_req),
    .pend_valid (pend_valid),
    .pend_waddr (pend_waddr),
    .pend_wdata (pend_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Scoreboard: every rf write must be the WB request or the next expected lu result.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (wb_we) begin
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== wb_waddr || rf_wdata !== wb_wdata) begin
          bad++;
          $display("FAIL wb_grant got we=%0b a=%0d d=%h exp we=1 a=%0d d=%h",
                   rf_we, rf_waddr, rf_wdata, wb_waddr, wb_wdata);
        end
      end else if (rf_we === 1'b1) begin
        total++;
        if (lu_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got a=%0d d=%h exp no write", rf_waddr, rf_wdata);
        end else begin
          wr_t e;
          e = lu_q.pop_front();
          if (rf_waddr !== e.a || rf_wdata !== e.d) begin
            bad++;
            $display("FAIL lu_order got a=%0d d=%h exp a=%0d d=%h", rf_waddr, rf_wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
  endtask

  task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1; wb_waddr = a; wb_wdata = d;
  endtask

  task automatic drive_lu(input logic [4:0] a, input logic [31:0] d);
    lu_valid = 1; lu_waddr = a; lu_wdata = d;
  endtask

  task automatic test_reset();
    idle_in();
    rst = 1;
    tick(); tick();
    rst = 0;
    @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL reset_lu_ready got=%0b exp=1", lu_ready); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    total++; if (pend_valid !== 1'b0 || pend_waddr !== 5'd0 || pend_wdata !== 32'd0) begin
      bad++; $display("FAIL reset_pend got v=%0b a=%0d d=%h exp 0/0/0", pend_valid, pend_waddr, pend_wdata);
    end
    mon_en = 1;
    tick();
  endtask

  task automatic test_direct();
    idle_in();
    drive_lu(5'd7, 32'hDEADBEEF);
    lu_q.push_back('{a: 5'd7, d: 32'hDEADBEEF});
    @(negedge clk);
`ifdef WBARB_DIRECT_EN
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      bad++; $display("FAIL direct_same_cycle got we=%0b a=%0d exp we=1 a=7", rf_we, rf_waddr);
    end
    total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL direct_no_push got=%0b exp=0", pend_valid); end
    tick(); idle_in();
    @(negedge clk);
    total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL direct_after got=%0b exp=0", pend_valid); end
`else
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL nodirect_first got we=%0b exp=0", rf_we); end
    tick(); idle_in();
    @(negedge clk);
    total++; if (pend_valid !== 1'b1 || pend_waddr !== 5'd7 || pend_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL nodirect_pend got v=%0b a=%0d d=%h exp 1/7/deadbeef", pend_valid, pend_waddr, pend_wdata);
    end
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      bad++; $display("FAIL nodirect_write got we=%0b a=%0d exp we=1 a=7", rf_we, rf_waddr);
    end
    tick();
    @(negedge clk);
    total++; if (pend_valid !== 1'b0) begin bad++; $display("FAIL nodirect_drained got=%0b exp=0", pend_valid); end
`endif
    tick();
  endtask

  task automatic test_wb_priority();
    idle_in();
    drive_wb(5'd3, 32'h0000_0033);
    drive_lu(5'd9, 32'h0000_0099);
    lu_q.push_back('{a: 5'd9, d: 32'h0000_0099});
    @(negedge clk);
    total++; if (rf_waddr !== 5'd3) begin bad++; $display("FAIL prio_wb got a=%0d exp 3", rf_waddr); end
    tick();
    idle_in();
    drive_wb(5'd4, 32'h0000_0044);
    @(negedge clk);
    total++; if (pend_valid !== 1'b1 || pend_waddr !== 5'd9 || pend_wdata !== 32'h99) begin
      bad++; $display("FAIL prio_pend got v=%0b a=%0d d=%h exp 1/9/99", pend_valid, pend_waddr, pend_wdata);
    end
    tick();
    idle_in();
    @(negedge clk);
    total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      bad++; $display("FAIL prio_drain got we=%0b a=%0d exp we=1 a=9", rf_we, rf_waddr);
    end
    tick();
  endtask

  task automatic test_starve();
    logic exp_stall;
    for (int k = 0; k < 11; k++) begin
      idle_in();
      if (k < 8) drive_wb(5'(k + 1), 32'h100 + k);
      if (k == 0) begin
        drive_lu(5'd10, 32'hA0A0_A0A0);
        lu_q.push_back('{a: 5'd10, d: 32'hA0A0_A0A0});
      end
      // waits start in cycle 1; forced from cycle SM+2 until the pop in cycle 8
      exp_stall = (k >= SM + 2) && (k <= 8);
      @(negedge clk);
      total++;
      if (stall_req !== exp_stall) begin
        bad++; $display("FAIL starve_stall cyc=%0d got=%0b exp=%0b", k, stall_req, exp_stall);
      end
      tick();
    end
  endtask

  task automatic test_full();
    logic exp_rdy;
    lu_q.push_back('{a: 5'd11, d: 32'h1111});
    lu_q.push_back('{a: 5'd12, d: 32'h1212});
    lu_q.push_back('{a: 5'd13, d: 32'h1313});
    for (int k = 0; k < 8; k++) begin
      idle_in();
      if (k < 4) drive_wb(5'(20 + k), 32'h200 + k);
      if (k == 0) drive_lu(5'd11, 32'h1111);
      if (k == 1) drive_lu(5'd12, 32'h1212);
      if (k >= 2 && k <= 5) drive_lu(5'd13, 32'h1313);
      exp_rdy = !(k >= 2 && k <= 4);
      @(negedge clk);
      total++;
      if (lu_ready !== exp_rdy) begin
        bad++; $display("FAIL full_ready cyc=%0d got=%0b exp=%0b", k, lu_ready, exp_rdy);
      end
      if (k == 3) begin
        total++;
        if (pend_waddr !== 5'd11) begin bad++; $display("FAIL full_head got a=%0d exp 11", pend_waddr); end
      end
      if (k == 7) begin
        total++;
        if (pend_valid !== 1'b0) begin bad++; $display("FAIL full_drained got=%0b exp=0", pend_valid); end
      end
      tick();
    end
  endtask

  task automatic test_zero_addr();
    idle_in();
    drive_lu(5'd0, 32'h1);
    @(negedge clk);
    total++; if (lu_ready !== 1'b1) begin bad++; $display("FAIL zero_ready got=%0b exp=1", lu_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL zero_write got=%0b exp=0", rf_we); end
    tick();
    idle_in();
    @(negedge clk);
    total++; if (pend_valid !== 1'b0 || rf_we !== 1'b0) begin
      bad++; $display("FAIL zero_push got v=%0b we=%0b exp 0/0", pend_valid, rf_we);
    end
    tick();
  endtask

  task automatic test_reset_flush();
    for (int k = 0; k < 7; k++) begin
      idle_in();
      drive_wb(5'(k + 1), 32'h300 + k);
      if (k == 0) drive_lu(5'd20, 32'h2020);
      if (k == 1) drive_lu(5'd21, 32'h2121);
      @(negedge clk);
      tick();
    end
    idle_in();
    drive_wb(5'd8, 32'h308);
    @(negedge clk);
    total++; if (stall_req !== 1'b1 || pend_valid !== 1'b1) begin
      bad++; $display("FAIL flush_pre got stall=%0b v=%0b exp 1/1", stall_req, pend_valid);
    end
    tick();
    idle_in();
    rst = 1;
    @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_rst_write got=%0b exp=0", rf_we); end
    tick();
    rst = 0;
    @(negedge clk);
    total++; if (pend_valid !== 1'b0 || stall_req !== 1'b0 || rf_we !== 1'b0 || lu_ready !== 1'b1) begin
      bad++; $display("FAIL flush_post got v=%0b stall=%0b we=%0b rdy=%0b exp 0/0/0/1",
                      pend_valid, stall_req, rf_we, lu_ready);
    end
    tick();
    @(negedge clk);
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL flush_late_write got=%0b exp=0", rf_we); end
    tick();
  endtask

  initial begin
    rst = 1;
    idle_in();
    test_reset();
    test_direct();
    test_wb_priority();
    test_starve();
    test_full();
    test_zero_addr();
    test_reset_flush();
    total++;
    if (lu_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d exp=0", lu_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
